// File: rtl/health_pkg.sv
// Shared constants and types for the pulse/heartbeat processing chain.
package health_pkg;

  localparam int unsigned DATA_W               = 10;
  localparam int unsigned DEF_AVG_LOG2         = 2;
  localparam int unsigned DEF_INT_W            = 12;
  localparam int unsigned DEF_TH_HI            = 600;
  localparam int unsigned DEF_TH_LO            = 500;
  localparam int unsigned DEF_MIN_INTERVAL     = 20;
  localparam int unsigned DEF_MAX_INTERVAL     = 4000;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } det_state_e;

endpackage : health_pkg

// File: rtl/pulse_beat_detector_moving_avg.sv
// Power-of-two moving average over the last 2**AVG_LOG2 samples, kept as a
// running sum so each update costs one add and one subtract.
module moving_avg
  import health_pkg::*;
#(
  parameter int unsigned DATA_W   = health_pkg::DATA_W,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0] taps_q [DEPTH];
  logic [DATA_W-1:0] taps_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    taps_d = taps_q;
    sum_d  = sum_q;
    avg_d  = avg_q;
    if (sample_valid) begin
      // The sum always contains the oldest tap, so this never underflows.
      sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(taps_q[DEPTH-1]);
      for (int i = DEPTH - 1; i > 0; i--) begin
        taps_d[i] = taps_q[i-1];
      end
      taps_d[0] = sample_in;
      avg_d     = DATA_W'(sum_d >> AVG_LOG2);
    end
  end

  // NOTE: the tap buffer is reset along with the sum; the running-sum
  // update relies on the taps and the sum agreeing from the first sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_q[i] <= '0;
      end
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      taps_q      <= taps_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= sample_valid;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;

endmodule : moving_avg

// File: rtl/pulse_beat_detector.sv
// Heartbeat detector: averaged signal, hysteresis thresholds, refractory
// window, beat-to-beat interval in samples and a no-signal timeout.
module pulse_beat_detector
  import health_pkg::*;
#(
  parameter int unsigned DATA_W       = health_pkg::DATA_W,
  parameter int unsigned AVG_LOG2     = DEF_AVG_LOG2,
  parameter int unsigned TH_HI        = DEF_TH_HI,
  parameter int unsigned TH_LO        = DEF_TH_LO,
  parameter int unsigned INT_W        = DEF_INT_W,
  parameter int unsigned MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int unsigned MAX_INTERVAL = DEF_MAX_INTERVAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              beat,
  output logic [INT_W-1:0]  interval,
  output logic              interval_valid,
  output logic              no_signal
);

  localparam logic [DATA_W-1:0] TH_HI_V = DATA_W'(TH_HI);
  localparam logic [DATA_W-1:0] TH_LO_V = DATA_W'(TH_LO);
  localparam logic [INT_W:0]    MIN_V   = (INT_W + 1)'(MIN_INTERVAL);
  localparam logic [INT_W:0]    MAX_V   = (INT_W + 1)'(MAX_INTERVAL);
  localparam logic [INT_W-1:0]  MAX_CNT = INT_W'(MAX_INTERVAL);

  moving_avg #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid)
  );

  det_state_e       state_q, state_d;
  logic [INT_W-1:0] cnt_q, cnt_d;
  logic [INT_W:0]   cnt_inc;
  logic             have_beat_q, have_beat_d;
  logic             beat_q, beat_d;
  logic [INT_W-1:0] interval_q, interval_d;
  logic             interval_valid_q, interval_valid_d;
  logic             no_signal_q, no_signal_d;
  logic             is_beat;

  // cnt+1 is the distance in samples from the last beat to the current one.
  assign cnt_inc = {1'b0, cnt_q} + (INT_W + 1)'(1);

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_beat = 1'b0;
    if (avg_valid) begin
      unique case (state_q)
        LOW: begin
          if ((avg_out > TH_HI_V) && (!have_beat_q || (cnt_inc >= MIN_V))) begin
            is_beat = 1'b1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (avg_out < TH_LO_V) begin
            state_d = LOW;
          end
        end
        default: state_d = LOW;
      endcase
    end
  end

  always_comb begin
    cnt_d            = cnt_q;
    have_beat_d      = have_beat_q;
    beat_d           = 1'b0;
    interval_d       = interval_q;
    interval_valid_d = 1'b0;
    no_signal_d      = no_signal_q;
    if (avg_valid) begin
      if (is_beat) begin
        beat_d = 1'b1;
        if (have_beat_q) begin
          interval_d       = cnt_inc[INT_W-1:0];
          interval_valid_d = 1'b1;
        end
        cnt_d       = '0;
        have_beat_d = 1'b1;
        no_signal_d = 1'b0;
      end else begin
        cnt_d = (cnt_inc >= MAX_V) ? MAX_CNT : cnt_inc[INT_W-1:0];
        // Timeout: the next beat restarts as a first beat.
        if (cnt_inc >= MAX_V) begin
          no_signal_d = 1'b1;
          have_beat_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q            <= '0;
      have_beat_q      <= 1'b0;
      beat_q           <= 1'b0;
      interval_q       <= '0;
      interval_valid_q <= 1'b0;
      no_signal_q      <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      have_beat_q      <= have_beat_d;
      beat_q           <= beat_d;
      interval_q       <= interval_d;
      interval_valid_q <= interval_valid_d;
      no_signal_q      <= no_signal_d;
    end
  end

  assign beat           = beat_q;
  assign interval       = interval_q;
  assign interval_valid = interval_valid_q;
  assign no_signal      = no_signal_q;

endmodule : pulse_beat_detector

// File: tb/tb_pulse_beat_detector.sv
// Self-checking bench for pulse_beat_detector: sample-index reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pulse_beat_detector;

  localparam int TH_HI   = 600;
  localparam int TH_LO   = 500;
  localparam int MIN_INT = 20;
  localparam int MAX_INT = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_in = '0;
  logic [9:0]  avg_out;
  logic        avg_valid;
  logic        beat;
  logic [11:0] interval;
  logic        interval_valid;
  logic        no_signal;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_beat_detector dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .avg_out       (avg_out),
    .avg_valid     (avg_valid),
    .beat          (beat),
    .interval      (interval),
    .interval_valid(interval_valid),
    .no_signal     (no_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, indexed by sample number since the last reset.
  int  m_hist[4];
  int  m_idx, m_ref, m_avg, m_interval;
  bit  m_hi, m_have, m_nosig, p_beat, p_iv;

  task automatic model_reset();
    foreach (m_hist[i]) m_hist[i] = 0;
    m_idx = 0; m_ref = -1; m_avg = 0; m_interval = 0;
    m_hi = 0; m_have = 0; m_nosig = 0; p_beat = 0; p_iv = 0;
  endtask

  task automatic model_step(input int s);
    int sum, elapsed;
    bit b;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
    sum = 0;
    foreach (m_hist[i]) sum += m_hist[i];
    m_avg   = sum / 4;
    elapsed = m_idx - m_ref;
    b = !m_hi && (m_avg > TH_HI) && (!m_have || elapsed >= MIN_INT);
    p_beat = b;
    p_iv   = 0;
    if (b) begin
      if (m_have) begin
        p_iv = 1;
        m_interval = elapsed;
      end
      m_have = 1; m_nosig = 0; m_ref = m_idx; m_hi = 1;
    end else begin
      if (m_hi && m_avg < TH_LO) m_hi = 0;
      if (elapsed >= MAX_INT) begin
        m_nosig = 1;
        m_have  = 0;
      end
    end
    m_idx++;
  endtask

  // Tallies of what the DUT emitted, for the directed literal checks.
  int dut_beats, dut_ivs, dut_last_iv;
  int avg_log[$];

  task automatic clear_tallies();
    dut_beats = 0; dut_ivs = 0; dut_last_iv = -1;
    avg_log.delete();
  endtask

  // Compare process: samples 1 time unit after each rising edge.
  initial begin
    model_reset();
    clear_tallies();
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        model_reset();
        check("outputs_in_reset",
              {avg_out, avg_valid, beat, interval, interval_valid, no_signal}, 0);
      end else begin
        check("beat", beat, p_beat);
        check("interval_valid", interval_valid, p_iv);
        check("interval", interval, m_interval);
        check("no_signal", no_signal, m_nosig);
        if (beat) dut_beats++;
        if (interval_valid) begin
          dut_ivs++;
          dut_last_iv = int'(interval);
        end
        p_beat = 0;
        p_iv   = 0;
        if (sample_valid) model_step(int'(sample_in));
        check("avg_valid", avg_valid, sample_valid);
        check("avg_out", avg_out, m_avg);
        if (avg_valid) avg_log.push_back(int'(avg_out));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 10'(s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  task automatic drive_n(input int s, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      drive(s);
      if (gapped) idle(1);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    clear_tallies();
  endtask

  task automatic periodic(input bit gapped);
    reset_dut();
    for (int p = 0; p < 4; p++) begin
      drive_n(800, 25, gapped);
      drive_n(0, 25, gapped);
    end
    idle(3);
    check("periodic_beats", dut_beats, 4);
    check("periodic_ivs", dut_ivs, 3);
    check("periodic_interval", dut_last_iv, 50);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {avg_out, avg_valid, beat, interval, interval_valid, no_signal}, 0);
    rst = 1'b0;
    clear_tallies();

    // Averaging ramp from an all-zero buffer.
    drive(100); idle(1); drive(200); idle(1);
    drive(300); idle(1); drive(400); idle(3);
    check("avg_count", avg_log.size(), 4);
    if (avg_log.size() == 4) begin
      check("avg_0", avg_log[0], 25);
      check("avg_1", avg_log[1], 75);
      check("avg_2", avg_log[2], 150);
      check("avg_3", avg_log[3], 250);
    end

    // First beat timing, then hysteresis: avg 600 keeps HIGH, 250 drops LOW.
    reset_dut();
    drive_n(800, 3, 1'b1);
    drive(800);
    @(posedge clk); #2;
    check("first_avg_valid", avg_valid, 1);
    check("first_avg_800", avg_out, 800);
    check("first_beat_not_early", beat, 0);
    idle(1);
    @(posedge clk); #2;
    check("first_beat_2cyc", beat, 1);
    check("first_beat_no_iv", interval_valid, 0);
    drive_n(0, 1, 1'b1);
    drive_n(1000, 25, 1'b1);
    idle(3);
    check("hyst_no_beat_in_high", dut_beats, 1);
    drive_n(0, 4, 1'b1);
    drive_n(800, 4, 1'b1);
    idle(3);
    check("hyst_rebeat", dut_beats, 2);
    check("hyst_interval", dut_last_iv, 34);

    // Refractory: crossing at cnt+1=10 rejected, accepted at cnt+1=20.
    reset_dut();
    drive_n(800, 4, 1'b1);
    drive_n(0, 6, 1'b1);
    drive_n(800, 14, 1'b1);
    idle(3);
    check("refr_beats", dut_beats, 2);
    check("refr_ivs", dut_ivs, 1);
    check("refr_interval", dut_last_iv, 20);

    // Periodic square wave, gapped and back-to-back.
    periodic(1'b1);
    periodic(1'b0);

    // Timeout after 4000 quiet samples, then recovery.
    reset_dut();
    drive_n(800, 4, 1'b0);
    drive_n(0, 3999, 1'b0);
    idle(3);
    check("timeout_not_yet", no_signal, 0);
    drive(0);
    idle(3);
    check("timeout_no_signal", no_signal, 1);
    drive_n(800, 4, 1'b0);
    idle(3);
    check("timeout_beat", dut_beats, 2);
    check("timeout_first_no_iv", dut_ivs, 0);
    check("timeout_cleared", no_signal, 0);
    drive_n(0, 26, 1'b0);
    drive_n(800, 4, 1'b0);
    idle(3);
    check("timeout_next_ivs", dut_ivs, 1);
    check("timeout_next_interval", dut_last_iv, 30);

    // Asynchronous reset mid-stream with cnt=37 and state HIGH.
    reset_dut();
    drive_n(800, 41, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sample_valid = 1'b0;
    #1;
    check("midreset_outputs",
          {avg_out, avg_valid, beat, interval, interval_valid, no_signal}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_tallies();
    idle(3);
    check("midreset_no_pulse", dut_beats + dut_ivs, 0);
    drive_n(800, 4, 1'b1);
    idle(3);
    check("midreset_beat", dut_beats, 1);
    check("midreset_no_iv", dut_ivs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pulse_beat_detector
